proc_datapath: RTL and testbench

Datapath of the 16-bit multicycle processor. It holds the register file R0–R7 (R7 doubles as the program counter), IR, the A/G ALU registers, the memory-interface registers ADDR/DOUT/W, and the condition flags. It sits directly downstream of the control FSM: it consumes the FSM's select, load-enable and PC-increment strobes every cycle. It returns `IR_out` and the flags to the FSM, and presents ADDR/DOUT/W to the memory bus.

---
 rtl/proc_pkg.sv | 31 +++
 rtl/proc_datapath_if.sv | 39 +++
 rtl/proc_alu.sv | 31 +++
 rtl/proc_datapath.sv | 111 +++++++++++
 tb/tb_proc_datapath.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared constants for the 16-bit multicycle processor: data width, bus
// source select codes, opcodes and the immediate decoder.
package proc_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;

  localparam logic [3:0] SEL_PC_REG = 4'd7;
  localparam logic [3:0] SEL_IR_REG = 4'd8;
  localparam logic [3:0] SEL_G_REG  = 4'd9;
  localparam logic [3:0] SEL_DIN    = 4'd10;

  typedef enum logic [2:0] {
    OP_MV  = 3'd0,
    OP_MVT = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_LD  = 3'd4,
    OP_ST  = 3'd5,
    OP_AND = 3'd6
  } opcode_t;

  // MVT places its 8-bit field in the upper byte; everything else zero-extends 9 bits.
  function automatic logic [DATA_W-1:0] imm_decode(input logic [DATA_W-1:0] ir);
    if (ir[15:13] == 3'(OP_MVT))
      return {ir[7:0], 8'h00};
    else
      return {7'b0, ir[8:0]};
  endfunction

endpackage

// File: rtl/proc_datapath_if.sv
// Control/status bundle between the control FSM and the datapath, plus the
// memory-side DIN/ADDR/DOUT/W signals.
interface proc_datapath_if;
  import proc_pkg::*;

  logic [DATA_W-1:0] DIN;
  logic [3:0]        sel;
  logic [NREGS-1:0]  RX_in;
  logic              IR_in;
  logic              A_in;
  logic              G_in;
  logic              ADDR_in;
  logic              DOUT_in;
  logic              PC_in;
  logic              pc_incr;
  logic              add_sub_ctrl;
  logic              W_inp;

  logic [DATA_W-1:0] IR_out;
  logic [DATA_W-1:0] ADDR;
  logic [DATA_W-1:0] DOUT;
  logic              W;
  logic              cout;
  logic              z_flag;
  logic              n_flag;

  modport master (
    output DIN, sel, RX_in, IR_in, A_in, G_in, ADDR_in, DOUT_in, PC_in,
           pc_incr, add_sub_ctrl, W_inp,
    input  IR_out, ADDR, DOUT, W, cout, z_flag, n_flag
  );

  modport slave (
    input  DIN, sel, RX_in, IR_in, A_in, G_in, ADDR_in, DOUT_in, PC_in,
           pc_incr, add_sub_ctrl, W_inp,
    output IR_out, ADDR, DOUT, W, cout, z_flag, n_flag
  );

endinterface

// File: rtl/proc_alu.sv
// Combinational ALU: add, subtract (two's complement via ~bus + 1) or AND.
module proc_alu
  import proc_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] bus,
  input  logic              add_sub_ctrl,
  input  logic [2:0]        opcode,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              neg
);

  logic [DATA_W:0] sum;

  // Carry out of the 17-bit sum; for subtract it reads as "no borrow".
  always_comb begin
    sum = {1'b0, a} + {1'b0, (add_sub_ctrl ? ~bus : bus)} + 17'(add_sub_ctrl);
    if (opcode == 3'(OP_AND)) begin
      result = a & bus;
      carry  = 1'b0;
    end else begin
      result = sum[DATA_W-1:0];
      carry  = sum[DATA_W];
    end
    zero = (result == '0);
    neg  = result[DATA_W-1];
  end

endmodule

// File: rtl/proc_datapath.sv
// Datapath of the 16-bit multicycle processor: register file R0-R7 (R7 = PC),
// IR, A/G, memory interface registers and condition flags.
module proc_datapath
  import proc_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  proc_datapath_if.slave dp
);

  logic [DATA_W-1:0] r [NREGS];
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] g_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] dout_q;
  logic              w_q;
  logic              cout_q;
  logic              z_q;
  logic              n_q;

  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic              alu_zero;
  logic              alu_neg;

  assign imm = imm_decode(ir_q);

  // Bus source mux; codes above SEL_DIN drive zero.
  always_comb begin
    bus = '0;
    if (!dp.sel[3]) begin
      bus = r[dp.sel[2:0]];
    end else begin
      case (dp.sel)
        SEL_IR_REG: bus = imm;
        SEL_G_REG:  bus = g_q;
        SEL_DIN:    bus = dp.DIN;
        default:    bus = '0;
      endcase
    end
  end

  proc_alu u_alu (
    .a            (a_q),
    .bus          (bus),
    .add_sub_ctrl (dp.add_sub_ctrl),
    .opcode       (ir_q[15:13]),
    .result       (alu_res),
    .carry        (alu_carry),
    .zero         (alu_zero),
    .neg          (alu_neg)
  );

  // Register file; R7 gives a bus load priority over the PC increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NREGS; k++) r[k] <= '0;
    end else begin
      for (int k = 0; k < NREGS - 1; k++)
        if (!dp.RX_in[k]) r[k] <= bus;
      if (!dp.RX_in[NREGS-1] || !dp.PC_in)
        r[NREGS-1] <= bus;
      else if (dp.pc_incr)
        r[NREGS-1] <= r[NREGS-1] + 16'd1;
    end
  end

  // IR, A, ADDR, DOUT loads and the registered write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q   <= '0;
      a_q    <= '0;
      addr_q <= '0;
      dout_q <= '0;
      w_q    <= 1'b0;
    end else begin
      if (!dp.IR_in)   ir_q   <= dp.DIN;
      if (!dp.A_in)    a_q    <= bus;
      if (!dp.ADDR_in) addr_q <= bus;
      if (!dp.DOUT_in) dout_q <= bus;
      w_q <= dp.W_inp;
    end
  end

  // G and the flags capture the ALU together and hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      g_q    <= '0;
      cout_q <= 1'b0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
    end else if (!dp.G_in) begin
      g_q    <= alu_res;
      cout_q <= alu_carry;
      z_q    <= alu_zero;
      n_q    <= alu_neg;
    end
  end

  assign dp.IR_out = ir_q;
  assign dp.ADDR   = addr_q;
  assign dp.DOUT   = dout_q;
  assign dp.W      = w_q;
  assign dp.cout   = cout_q;
  assign dp.z_flag = z_q;
  assign dp.n_flag = n_q;

endmodule

// File: tb/tb_proc_datapath.sv
// Testbench for proc_datapath: directed processor sequences plus random
// control traffic, compared every cycle against a behavioural model.
module tb_proc_datapath;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  proc_datapath_if dp_if ();

  proc_datapath dut (
    .clk   (clk),
    .reset (reset),
    .dp    (dp_if)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [15:0] m_r [8];
  logic [15:0] m_ir, m_a, m_g, m_addr, m_dout;
  logic        m_w, m_c, m_z, m_n;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_idle;
    reset              = 1'b0;
    dp_if.DIN          = 16'h0000;
    dp_if.sel          = 4'd0;
    dp_if.RX_in        = 8'hFF;
    dp_if.IR_in        = 1'b1;
    dp_if.A_in         = 1'b1;
    dp_if.G_in         = 1'b1;
    dp_if.ADDR_in      = 1'b1;
    dp_if.DOUT_in      = 1'b1;
    dp_if.PC_in        = 1'b1;
    dp_if.pc_incr      = 1'b0;
    dp_if.add_sub_ctrl = 1'b0;
    dp_if.W_inp        = 1'b0;
  endtask

  // Next model state from the current inputs, using plain arithmetic.
  task automatic model_update;
    logic [15:0] bus, imm, res;
    logic        co;
    int          s;
    imm = (m_ir[15:13] == 3'd1) ? {m_ir[7:0], 8'h00} : {7'd0, m_ir[8:0]};
    if (dp_if.sel < 4'd8)        bus = m_r[dp_if.sel[2:0]];
    else if (dp_if.sel == 4'd8)  bus = imm;
    else if (dp_if.sel == 4'd9)  bus = m_g;
    else if (dp_if.sel == 4'd10) bus = dp_if.DIN;
    else                         bus = 16'h0000;

    if (m_ir[15:13] == 3'd6) begin
      res = m_a & bus;
      co  = 1'b0;
    end else begin
      if (dp_if.add_sub_ctrl) s = int'(m_a) - int'(bus) + 65536;
      else                    s = int'(m_a) + int'(bus);
      res = s[15:0];
      co  = (s >= 65536);
    end

    if (reset) begin
      for (int k = 0; k < 8; k++) m_r[k] = 16'h0000;
      m_ir = 0; m_a = 0; m_g = 0; m_addr = 0; m_dout = 0;
      m_w = 0; m_c = 0; m_z = 0; m_n = 0;
    end else begin
      for (int k = 0; k < 7; k++)
        if (!dp_if.RX_in[k]) m_r[k] = bus;
      if (!dp_if.RX_in[7] || !dp_if.PC_in) m_r[7] = bus;
      else if (dp_if.pc_incr)              m_r[7] = 16'((int'(m_r[7]) + 1) % 65536);
      if (!dp_if.IR_in)   m_ir   = dp_if.DIN;
      if (!dp_if.A_in)    m_a    = bus;
      if (!dp_if.ADDR_in) m_addr = bus;
      if (!dp_if.DOUT_in) m_dout = bus;
      if (!dp_if.G_in) begin
        m_g = res;
        m_c = co;
        m_z = (res == 16'h0000);
        m_n = res[15];
      end
      m_w = dp_if.W_inp;
    end
  endtask

  // One clock: advance the model, then compare every output after the edge.
  task automatic tick;
    model_update();
    @(posedge clk);
    #1;
    check_val("IR_out", dp_if.IR_out, m_ir);
    check_val("ADDR",   dp_if.ADDR,   m_addr);
    check_val("DOUT",   dp_if.DOUT,   m_dout);
    check_val("W",      16'(dp_if.W),      16'(m_w));
    check_val("cout",   16'(dp_if.cout),   16'(m_c));
    check_val("z_flag", 16'(dp_if.z_flag), 16'(m_z));
    check_val("n_flag", 16'(dp_if.n_flag), 16'(m_n));
  endtask

  task automatic load_reg(input int k, input logic [15:0] val);
    logic [7:0] one_hot;
    one_hot      = 8'd1 << k;
    dp_if.DIN    = val;
    dp_if.sel    = 4'd10;
    dp_if.RX_in  = ~one_hot;
    tick();
    set_idle();
  endtask

  task automatic load_ir(input logic [15:0] val);
    dp_if.DIN   = val;
    dp_if.IR_in = 1'b0;
    tick();
    set_idle();
  endtask

  task automatic load_a(input logic [15:0] val);
    dp_if.DIN  = val;
    dp_if.sel  = 4'd10;
    dp_if.A_in = 1'b0;
    tick();
    set_idle();
  endtask

  // Route a bus source into ADDR and compare it with a known constant.
  task automatic read_src(input logic [3:0] code, input string tag, input logic [15:0] exp);
    dp_if.sel     = code;
    dp_if.ADDR_in = 1'b0;
    tick();
    check_val(tag, dp_if.ADDR, exp);
    set_idle();
  endtask

  initial begin
    set_idle();

    // Reset overrides every enable and write request
    reset          = 1'b1;
    dp_if.DIN      = 16'hABCD;
    dp_if.sel      = 4'd10;
    dp_if.RX_in    = 8'h00;
    dp_if.IR_in    = 1'b0;
    dp_if.A_in     = 1'b0;
    dp_if.G_in     = 1'b0;
    dp_if.ADDR_in  = 1'b0;
    dp_if.DOUT_in  = 1'b0;
    dp_if.PC_in    = 1'b0;
    dp_if.pc_incr  = 1'b1;
    dp_if.W_inp    = 1'b1;
    tick();
    check_val("rst_IR",   dp_if.IR_out, 16'h0000);
    check_val("rst_ADDR", dp_if.ADDR,   16'h0000);
    check_val("rst_DOUT", dp_if.DOUT,   16'h0000);
    check_val("rst_W",    16'(dp_if.W), 16'h0000);
    check_val("rst_flags", 16'({dp_if.cout, dp_if.z_flag, dp_if.n_flag}), 16'h0000);
    set_idle();
    for (int k = 0; k < 8; k++) read_src(4'(k), "rst_Rk", 16'h0000);
    read_src(4'd9, "rst_G", 16'h0000);

    // Fetch: PC=5, T0 ADDR<-PC and PC++, T1 wait, T2 IR<-DIN
    load_reg(7, 16'h0005);
    dp_if.sel = 4'd7; dp_if.ADDR_in = 1'b0; dp_if.pc_incr = 1'b1;
    tick();
    check_val("fetch_ADDR", dp_if.ADDR, 16'h0005);
    set_idle();
    tick();
    dp_if.DIN = 16'h1234; dp_if.IR_in = 1'b0;
    tick();
    check_val("fetch_IR", dp_if.IR_out, 16'h1234);
    set_idle();
    read_src(4'd7, "fetch_PC", 16'h0006);

    // MV / MVT immediates
    load_ir(16'h01FF);
    dp_if.sel = 4'd8; dp_if.RX_in = 8'hFE;
    tick();
    set_idle();
    read_src(4'd0, "mv_R0", 16'h01FF);
    load_ir(16'h22AB);
    dp_if.sel = 4'd8; dp_if.RX_in = 8'hFD;
    tick();
    set_idle();
    read_src(4'd1, "mvt_R1", 16'hAB00);

    // ADD overflow
    load_ir(16'h4000);
    load_a(16'hFFFF);
    load_reg(2, 16'h0001);
    dp_if.sel = 4'd2; dp_if.G_in = 1'b0;
    tick();
    check_val("add_flags", 16'({dp_if.cout, dp_if.z_flag, dp_if.n_flag}), 16'b110);
    set_idle();
    read_src(4'd9, "add_G", 16'h0000);

    // SUB with borrow
    load_ir(16'h6000);
    load_a(16'h0003);
    load_reg(2, 16'h0005);
    dp_if.sel = 4'd2; dp_if.G_in = 1'b0; dp_if.add_sub_ctrl = 1'b1;
    tick();
    check_val("sub_flags", 16'({dp_if.cout, dp_if.z_flag, dp_if.n_flag}), 16'b001);
    set_idle();
    read_src(4'd9, "sub_G", 16'hFFFE);

    // AND
    load_ir(16'hC000);
    load_a(16'hF0F0);
    dp_if.DIN = 16'h0FF0; dp_if.sel = 4'd10; dp_if.G_in = 1'b0;
    tick();
    check_val("and_flags", 16'({dp_if.cout, dp_if.z_flag, dp_if.n_flag}), 16'b000);
    set_idle();
    read_src(4'd9, "and_G", 16'h00F0);

    // Store: T3 ADDR, T4 DOUT + W request, W one cycle later
    load_reg(3, 16'h0040);
    load_reg(4, 16'hBEEF);
    dp_if.sel = 4'd3; dp_if.ADDR_in = 1'b0;
    tick();
    set_idle();
    dp_if.sel = 4'd4; dp_if.DOUT_in = 1'b0; dp_if.W_inp = 1'b1;
    tick();
    check_val("st_ADDR", dp_if.ADDR, 16'h0040);
    check_val("st_DOUT", dp_if.DOUT, 16'hBEEF);
    check_val("st_W1",   16'(dp_if.W), 16'h0001);
    set_idle();
    tick();
    check_val("st_W0",   16'(dp_if.W), 16'h0000);

    // PC load beats increment; increment wraps
    dp_if.DIN = 16'h0100; dp_if.sel = 4'd10; dp_if.PC_in = 1'b0; dp_if.pc_incr = 1'b1;
    tick();
    set_idle();
    read_src(4'd7, "pc_load_prio", 16'h0100);
    load_reg(7, 16'hFFFF);
    dp_if.pc_incr = 1'b1;
    tick();
    set_idle();
    read_src(4'd7, "pc_wrap", 16'h0000);

    // Unused select codes drive zero
    read_src(4'd13, "sel_unused", 16'h0000);

    // Random control traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset              = ($urandom_range(0, 59) == 0);
      dp_if.DIN          = 16'($urandom);
      dp_if.sel          = 4'($urandom_range(0, 15));
      for (int k = 0; k < 8; k++) dp_if.RX_in[k] = ($urandom_range(0, 3) != 0);
      dp_if.IR_in        = ($urandom_range(0, 3) != 0);
      dp_if.A_in         = ($urandom_range(0, 2) != 0);
      dp_if.G_in         = ($urandom_range(0, 2) != 0);
      dp_if.ADDR_in      = ($urandom_range(0, 2) != 0);
      dp_if.DOUT_in      = ($urandom_range(0, 2) != 0);
      dp_if.PC_in        = ($urandom_range(0, 4) != 0);
      dp_if.pc_incr      = 1'($urandom_range(0, 1));
      dp_if.add_sub_ctrl = 1'($urandom_range(0, 1));
      dp_if.W_inp        = 1'($urandom_range(0, 1));
      tick();
    end
    set_idle();
    for (int k = 0; k < 8; k++) read_src(4'(k), "final_Rk", m_r[k]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
